// File: rtl/line_fill_ctrl_if.sv
// Wishbone master-side bus bundle used by line_fill_ctrl for single-word line transfers.
interface line_fill_ctrl_if;
    logic        m_cyc;
    logic        m_we;
    logic [3:0]  m_strb;
    logic [31:0] m_addr;
    logic [31:0] m_data_o;
    logic        m_ack;
    logic [31:0] m_data_i;

    modport master (
        output m_cyc, m_we, m_strb, m_addr, m_data_o,
        input  m_ack, m_data_i
    );

    modport slave (
        input  m_cyc, m_we, m_strb, m_addr, m_data_o,
        output m_ack, m_data_i
    );
endinterface

// File: rtl/line_fill_ctrl.sv
// Cache-line fill / write-back engine: one 8-word line request becomes 8 single-word Wishbone cycles.
// Optional macro CRITICAL_WORD_FIRST_EN starts fills at the requested word instead of word 0.
module line_fill_ctrl #(
    parameter int LINE_WORDS  = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    input  logic         req_we,
    input  logic [31:0]  req_addr,
    input  logic [255:0] wb_line,
    output logic         req_ready,
    output logic [255:0] fill_line,
    output logic         fill_done,
    output logic         wb_done,
    output logic         crit_valid,
    output logic         err,
    line_fill_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, BUS, GAP, DONE} state_t;

    state_t         state_q;
    logic           we_q;
    logic [26:0]    base_q;
    logic [2:0]     idx_q, crit_idx_q, beat_q;
    logic [7:0]     tmo_q;
    logic [255:0]   wb_q, fill_q;
    logic           req_ready_q, fill_done_q, wb_done_q, crit_q, err_q;
    logic           m_cyc_q, m_we_q;
    logic [3:0]     m_strb_q;
    logic [31:0]    m_addr_q, m_data_q;

    logic [2:0]     start_d, idx_nxt_d;
    logic           last_d, tmo_hit_d, unused_addr_d;

    function automatic logic [31:0] word_sel(input logic [255:0] line, input logic [2:0] i);
        return line[{i, 5'b0} +: 32];
    endfunction

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_d = req_we ? 3'd0 : req_addr[4:2];
`else
    assign start_d = 3'd0;
`endif

    assign idx_nxt_d     = idx_q + 3'd1;
    assign last_d        = (beat_q == 3'(LINE_WORDS - 1));
    assign tmo_hit_d     = (tmo_q == 8'(ACK_TIMEOUT - 1));
    assign unused_addr_d = ^req_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            base_q      <= '0;
            idx_q       <= '0;
            crit_idx_q  <= '0;
            beat_q      <= '0;
            tmo_q       <= '0;
            wb_q        <= '0;
            fill_q      <= '0;
            req_ready_q <= 1'b1;
            fill_done_q <= 1'b0;
            wb_done_q   <= 1'b0;
            crit_q      <= 1'b0;
            err_q       <= 1'b0;
            m_cyc_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_strb_q    <= '0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
        end else begin
            fill_done_q <= 1'b0;
            wb_done_q   <= 1'b0;
            crit_q      <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q     <= BUS;
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        base_q      <= req_addr[31:5];
                        idx_q       <= start_d;
                        crit_idx_q  <= req_addr[4:2];
                        beat_q      <= '0;
                        tmo_q       <= '0;
                        wb_q        <= wb_line;
                        m_cyc_q     <= 1'b1;
                        m_we_q      <= req_we;
                        m_strb_q    <= 4'hF;
                        m_addr_q    <= {req_addr[31:5], start_d, 2'b00};
                        m_data_q    <= word_sel(wb_line, start_d);
                    end
                end
                // An ack in the timeout cycle wins over the abort.
                BUS: begin
                    if (bus.m_ack) begin
                        if (!we_q) fill_q[{idx_q, 5'b0} +: 32] <= bus.m_data_i;
                        crit_q   <= !we_q && (idx_q == crit_idx_q);
                        beat_q   <= beat_q + 3'd1;
                        tmo_q    <= '0;
                        m_cyc_q  <= 1'b0;
                        m_strb_q <= '0;
                        if (last_d) begin
                            state_q     <= DONE;
                            fill_done_q <= !we_q;
                            wb_done_q   <= we_q;
                        end else begin
                            state_q <= GAP;
                        end
                    end else if (tmo_hit_d) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        err_q       <= 1'b1;
                        m_cyc_q     <= 1'b0;
                        m_we_q      <= 1'b0;
                        m_strb_q    <= '0;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                GAP: begin
                    state_q  <= BUS;
                    idx_q    <= idx_nxt_d;
                    m_cyc_q  <= 1'b1;
                    m_strb_q <= 4'hF;
                    m_addr_q <= {base_q, idx_nxt_d, 2'b00};
                    m_data_q <= word_sel(wb_q, idx_nxt_d);
                end
                DONE: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    m_we_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign fill_line    = fill_q;
    assign fill_done    = fill_done_q;
    assign wb_done      = wb_done_q;
    assign crit_valid   = crit_q;
    assign err          = err_q;
    assign bus.m_cyc    = m_cyc_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_strb   = m_strb_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_data_o = m_data_q;

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Self-checking bench for line_fill_ctrl: table-driven line requests, scoreboarded bus beats, corner sequences.
module tb_line_fill_ctrl;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        int          waits;
        logic [31:0] seed;
        int          exp_done;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_we = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [255:0] wb_line = '0;
    logic         req_ready, fill_done, wb_done, crit_valid, err;
    logic [255:0] fill_line;

    logic         s_ack = 1'b0;
    logic [31:0]  s_data = '0;
    int           wait_cfg = 0;
    int           wcnt = 0;
    int           acks = 0;
    bit           no_ack = 1'b0;
    bit           spur_en = 1'b0;
    logic [31:0]  mem [0:1023];
    beat_t        sbq [$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    vec_t         vecs [5];

    line_fill_ctrl_if bus ();
    assign bus.m_ack    = s_ack;
    assign bus.m_data_i = s_data;

    line_fill_ctrl #(.LINE_WORDS(8), .ACK_TIMEOUT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .wb_line    (wb_line),
        .req_ready  (req_ready),
        .fill_line  (fill_line),
        .fill_done  (fill_done),
        .wb_done    (wb_done),
        .crit_valid (crit_valid),
        .err        (err),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory slave: acks after wait_cfg wait states, checks each real beat against the scoreboard.
    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            s_ack = 1'b0;
            wcnt  = 0;
        end else if (bus.m_cyc) begin
            if (!no_ack && wcnt == wait_cfg) begin
                s_ack  = 1'b1;
                wcnt   = 0;
                acks++;
                s_data = mem[bus.m_addr[11:2]];
                if (bus.m_we) mem[bus.m_addr[11:2]] = bus.m_data_o;
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_beat", {224'd0, bus.m_addr}, 256'hFFFF_FFFF);
                end else begin
                    b = sbq.pop_front();
                    chk("beat_addr", {224'd0, bus.m_addr}, {224'd0, b.addr});
                    chk("beat_we", {255'd0, bus.m_we}, {255'd0, b.we});
                    chk("beat_strb", {252'd0, bus.m_strb}, 256'hF);
                    if (b.we) chk("beat_wdata", {224'd0, bus.m_data_o}, {224'd0, b.data});
                end
            end else begin
                s_ack = 1'b0;
                wcnt++;
            end
        end else begin
            s_ack  = spur_en;
            s_data = spur_en ? 32'hDEAD_BEEF : 32'h0;
            wcnt   = 0;
        end
    end

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [255:0] wl, output int t0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        wb_line   = wl;
        @(posedge clk);
        #1;
        t0 = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_before"}, {255'd0, req_ready}, 256'd1);
    endtask

    task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                           input int waits, input logic [31:0] seed, input int exp_done);
        logic [255:0] wl, exp_fill;
        logic [2:0]   start, ix;
        beat_t        b;
        int t0, rel, done_rel, crit_rel, crit_cnt, fd, wd, ec, crit_k;
        wait_ready(tag);
        wait_cfg = waits;
        for (int i = 0; i < 8; i++) wl[32*i +: 32] = seed + 32'(i);
`ifdef CRITICAL_WORD_FIRST_EN
        start  = we ? 3'd0 : addr[4:2];
        crit_k = 1;
`else
        start  = 3'd0;
        crit_k = int'(addr[4:2]) + 1;
`endif
        exp_fill = '0;
        for (int k = 0; k < 8; k++) begin
            ix     = start + 3'(k);
            b.addr = {addr[31:5], ix, 2'b00};
            b.we   = we;
            b.data = wl[32*ix +: 32];
            sbq.push_back(b);
        end
        for (int i = 0; i < 8; i++) exp_fill[32*i +: 32] = mem[{addr[11:5], 3'(i)}];
        drive_req(we, addr, wl, t0);
        done_rel = 0; crit_rel = 0; crit_cnt = 0; fd = 0; wd = 0; ec = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            rel = cyc - t0 + 1;
            if (crit_valid) begin crit_cnt++; crit_rel = rel; end
            if (fill_done) fd++;
            if (wb_done) wd++;
            if (err) ec++;
            if (fill_done || wb_done || err) begin done_rel = rel; break; end
        end
        chk({tag, "_done_cycle"}, 256'(done_rel), 256'(exp_done));
        chk({tag, "_fill_done_cnt"}, 256'(fd), we ? 256'd0 : 256'd1);
        chk({tag, "_wb_done_cnt"}, 256'(wd), we ? 256'd1 : 256'd0);
        chk({tag, "_err_cnt"}, 256'(ec), 256'd0);
        chk({tag, "_crit_cnt"}, 256'(crit_cnt), we ? 256'd0 : 256'd1);
        if (!we) chk({tag, "_crit_cycle"}, 256'(crit_rel), 256'(crit_k * (waits + 2)));
        chk({tag, "_sb_left"}, 256'(sbq.size()), 256'd0);
        @(negedge clk);
        chk({tag, "_ready_after"}, {255'd0, req_ready}, 256'd1);
        chk({tag, "_pulse_low"}, {254'd0, fill_done, wb_done}, 256'd0);
        if (!we) chk({tag, "_fill_line"}, fill_line, exp_fill);
        else for (int i = 0; i < 8; i++)
            chk({tag, "_mem_word"}, {224'd0, mem[{addr[11:5], 3'(i)}]}, {224'd0, wl[32*i +: 32]});
    endtask

    initial begin
        int t0, rel, hi, ec, dc, err_rel;
        logic rdy_at_err;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        vecs[0] = '{1'b0, 32'h0000_0104, 0, 32'h0,  16};
        vecs[1] = '{1'b1, 32'h0000_0200, 0, 32'hA0, 16};
        vecs[2] = '{1'b0, 32'h0000_011C, 1, 32'h0,  24};
        vecs[3] = '{1'b1, 32'h0000_0340, 1, 32'h55, 24};
        vecs[4] = '{1'b0, 32'h0000_00E8, 0, 32'h0,  16};

        repeat (3) @(negedge clk);
        chk("rst_ready", {255'd0, req_ready}, 256'd1);
        chk("rst_bus_ctl", {250'd0, bus.m_cyc, bus.m_we, bus.m_strb}, 256'd0);
        chk("rst_bus_data", {192'd0, bus.m_addr, bus.m_data_o}, 256'd0);
        chk("rst_fill_line", fill_line, 256'd0);
        chk("rst_pulses", {252'd0, fill_done, wb_done, crit_valid, err}, 256'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++)
            run_req($sformatf("vec%0d", v), vecs[v].we, vecs[v].addr, vecs[v].waits, vecs[v].seed, vecs[v].exp_done);

        // Slave never answers: abort after ACK_TIMEOUT bus cycles.
        wait_ready("tmo");
        no_ack = 1'b1;
        drive_req(1'b0, 32'h0000_0300, '0, t0);
        hi = 0; ec = 0; dc = 0; err_rel = 0; rdy_at_err = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            rel = cyc - t0 + 1;
            if (bus.m_cyc) hi++;
            if (err) begin ec++; err_rel = rel; rdy_at_err = req_ready; end
            if (fill_done || wb_done) dc++;
        end
        no_ack = 1'b0;
        chk("tmo_cyc_high", 256'(hi), 256'd8);
        chk("tmo_err_cnt", 256'(ec), 256'd1);
        chk("tmo_err_cycle", 256'(err_rel), 256'd9);
        chk("tmo_done_cnt", 256'(dc), 256'd0);
        chk("tmo_ready", {255'd0, rdy_at_err}, 256'd1);

        // Reset asserted during beat 3 of a fill.
        wait_ready("rst_mid");
        wait_cfg = 1;
        for (int k = 0; k < 8; k++) sbq.push_back('{{27'h8, 3'(k), 2'b00}, 1'b0, 32'h0});
        drive_req(1'b0, 32'h0000_0100, '0, t0);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (acks >= 2 && bus.m_cyc) break;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", {255'd0, bus.m_cyc}, 256'd0);
        chk("rst_mid_ready", {255'd0, req_ready}, 256'd1);
        chk("rst_mid_bus", {187'd0, bus.m_we, bus.m_strb, bus.m_addr, bus.m_data_o}, 256'd0);
        chk("rst_mid_fill_line", fill_line, 256'd0);
        chk("rst_mid_pulses", {252'd0, fill_done, wb_done, crit_valid, err}, 256'd0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_req("after_rst", 1'b0, 32'h0000_0180, 0, 32'h0, 16);

        // Spurious acks while m_cyc is low must be ignored.
        spur_en = 1'b1;
        run_req("spur", 1'b0, 32'h0000_0104, 0, 32'h0, 16);
        spur_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
